// File: rtl/l2_request_scheduler_if.sv
// Handshake and grant bundle between the request sources and the L2 request scheduler.
// master: the side that raises requests and watches grants.
// slave:  the scheduler.
interface l2_request_scheduler_if #(
  parameter int unsigned NUM_CORES = 4
);
  localparam int unsigned CIDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] core_request_valid;
  logic [NUM_CORES-1:0] core_ready;
  logic                 restart_valid;
  logic                 restart_ready;
  logic                 downstream_stall;
  logic                 grant_valid;
  logic                 grant_is_restart;
  logic [CIDW-1:0]      grant_core_id;

  modport master (
    output core_request_valid,
    output restart_valid,
    output downstream_stall,
    input  core_ready,
    input  restart_ready,
    input  grant_valid,
    input  grant_is_restart,
    input  grant_core_id
  );

  modport slave (
    input  core_request_valid,
    input  restart_valid,
    input  downstream_stall,
    output core_ready,
    output restart_ready,
    output grant_valid,
    output grant_is_restart,
    output grant_core_id
  );
endinterface

// File: rtl/l2_request_scheduler.sv
// L2 request scheduler: arbitrates the single L2 pipeline issue slot between NUM_CORES core
// ports and the restarted-request port. Restarts win unless the burst limiter holds them off;
// cores share by round-robin with a per-core starvation override.
// Optional feature macro: L2_SCHED_PERF_EN enables the three 32-bit grant counters; without it
// the perf ports read zero and no counter state exists.
module l2_request_scheduler #(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned MAX_RESTART_BURST = 8,
  parameter int unsigned STARVE_LIMIT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_request_scheduler_if.slave bus,
  output logic [31:0]           perf_restart_grants,
  output logic [31:0]           perf_core_grants,
  output logic [31:0]           perf_starve_overrides
);

  localparam int unsigned CIDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned WCW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BCW  = $clog2(MAX_RESTART_BURST + 1);

  logic [CIDW-1:0] rr_q, rr_d;
  logic [WCW-1:0]  wait_q [NUM_CORES];
  logic [WCW-1:0]  wait_d [NUM_CORES];
  logic [BCW-1:0]  burst_q, burst_d;
  logic            hold_q, hold_d;

  logic            grant_valid_q;
  logic            grant_is_restart_q;
  logic [CIDW-1:0] grant_core_id_q;

  logic                 issue;
  logic                 any_core;
  logic                 restart_grant;
  logic                 starve_hit;
  logic                 sel_found;
  logic [CIDW-1:0]      sel_id;
  logic [NUM_CORES-1:0] core_grant;
  logic                 core_grant_any;
  int                   rr_idx;

  // Pick this cycle's winner: restart first, then starved core, then round-robin.
  always_comb begin
    // Readies are held low during reset so nothing looks accepted while state is cleared.
    issue         = !bus.downstream_stall && !reset;
    any_core      = |bus.core_request_valid;
    restart_grant = bus.restart_valid && !hold_q && issue;

    starve_hit = 1'b0;
    sel_id     = '0;
    rr_idx     = 0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (!starve_hit && bus.core_request_valid[i] && (wait_q[i] == WCW'(STARVE_LIMIT))) begin
        starve_hit = 1'b1;
        sel_id     = CIDW'(i);
      end
    end

    sel_found = starve_hit;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      rr_idx = (int'(rr_q) + k) % int'(NUM_CORES);
      if (!sel_found && bus.core_request_valid[rr_idx]) begin
        sel_found = 1'b1;
        sel_id    = CIDW'(rr_idx);
      end
    end

    core_grant = '0;
    if (issue && !restart_grant && any_core) begin
      core_grant[sel_id] = 1'b1;
    end
    core_grant_any = |core_grant;
  end

  assign bus.restart_ready = restart_grant;
  assign bus.core_ready    = core_grant;

  // Next state for round-robin pointer, wait counters and burst limiter.
  always_comb begin
    rr_d = rr_q;
    if (core_grant_any) begin
      rr_d = (sel_id == CIDW'(NUM_CORES - 1)) ? '0 : sel_id + CIDW'(1);
    end

    for (int i = 0; i < int'(NUM_CORES); i++) begin
      wait_d[i] = wait_q[i];
      if (!bus.core_request_valid[i] || core_grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WCW'(STARVE_LIMIT)) begin
        wait_d[i] = wait_q[i] + WCW'(1);
      end
    end

    burst_d = burst_q;
    hold_d  = hold_q;
    if (core_grant_any || !any_core) begin
      burst_d = '0;
      hold_d  = 1'b0;
    end else if (restart_grant) begin
      burst_d = burst_q + BCW'(1);
      if (burst_q == BCW'(MAX_RESTART_BURST - 1)) begin
        hold_d = 1'b1;
      end
    end
  end

  // Arbitration state and registered grant report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q               <= '0;
      burst_q            <= '0;
      hold_q             <= 1'b0;
      grant_valid_q      <= 1'b0;
      grant_is_restart_q <= 1'b0;
      grant_core_id_q    <= '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      rr_q               <= rr_d;
      burst_q            <= burst_d;
      hold_q             <= hold_d;
      grant_valid_q      <= restart_grant || core_grant_any;
      grant_is_restart_q <= restart_grant;
      grant_core_id_q    <= core_grant_any ? sel_id : '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign bus.grant_valid      = grant_valid_q;
  assign bus.grant_is_restart = grant_is_restart_q;
  assign bus.grant_core_id    = grant_core_id_q;

`ifdef L2_SCHED_PERF_EN
  logic [31:0] perf_restart_q;
  logic [31:0] perf_core_q;
  logic [31:0] perf_starve_q;

  // Grant counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_restart_q <= '0;
      perf_core_q    <= '0;
      perf_starve_q  <= '0;
    end else begin
      if (restart_grant) begin
        perf_restart_q <= perf_restart_q + 32'd1;
      end
      if (core_grant_any) begin
        perf_core_q <= perf_core_q + 32'd1;
      end
      if (core_grant_any && starve_hit) begin
        perf_starve_q <= perf_starve_q + 32'd1;
      end
    end
  end

  assign perf_restart_grants   = perf_restart_q;
  assign perf_core_grants      = perf_core_q;
  assign perf_starve_overrides = perf_starve_q;
`else
  assign perf_restart_grants   = 32'd0;
  assign perf_core_grants      = 32'd0;
  assign perf_starve_overrides = 32'd0;
`endif

  // At most one ready per cycle, and none while the pipeline stalls.
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.restart_ready, bus.core_ready}));
  a_no_ready_in_stall : assert property (@(posedge clk) disable iff (reset)
    bus.downstream_stall |-> !(bus.restart_ready || (|bus.core_ready)));

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Directed bench for l2_request_scheduler (NUM_CORES=4, MAX_RESTART_BURST=8, STARVE_LIMIT=16).
module tb_l2_request_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perf_r;
  logic [31:0] perf_c;
  logic [31:0] perf_s;

  always #5 clk = ~clk;

  l2_request_scheduler_if #(.NUM_CORES(4)) bus ();

  l2_request_scheduler #(
    .NUM_CORES        (4),
    .MAX_RESTART_BURST(8),
    .STARVE_LIMIT     (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .perf_restart_grants  (perf_r),
    .perf_core_grants     (perf_c),
    .perf_starve_overrides(perf_s)
  );

  typedef struct packed {
    logic       v;
    logic       r;
    logic [1:0] id;
  } grant_t;

  grant_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, check readies, queue expected grant, check it after posedge.
  task automatic cyc(input logic [3:0] cv, input logic rv, input logic st, input logic exp_rr,
                     input logic [3:0] exp_cr, input string tag);
    grant_t e;
    grant_t o;
    @(negedge clk);
    bus.core_request_valid = cv;
    bus.restart_valid      = rv;
    bus.downstream_stall   = st;
    #1;
    check({tag, "/ready"}, {27'd0, bus.restart_ready, bus.core_ready}, {27'd0, exp_rr, exp_cr});
    e.v  = exp_rr | (|exp_cr);
    e.r  = exp_rr;
    e.id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (exp_cr[i]) e.id = 2'(i);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = {bus.grant_valid, bus.grant_is_restart, bus.grant_core_id};
    e = sb.pop_front();
    check({tag, "/grant"}, 32'(o), 32'(e));
  endtask

  // Reset cycle with all visible outputs expected at zero.
  task automatic reset_cycle(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "/ready"}, {27'd0, bus.restart_ready, bus.core_ready}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "/grant"}, {29'd0, bus.grant_valid, bus.grant_is_restart, bus.grant_core_id},
          32'd0);
    check({tag, "/perf"}, perf_r | perf_c | perf_s, 32'd0);
  endtask

  initial begin
    reset                  = 1'b1;
    bus.core_request_valid = 4'b0000;
    bus.restart_valid      = 1'b1;
    bus.downstream_stall   = 1'b0;

    // Reset held with a restart pending, then first grant is the restart.
    for (int i = 0; i < 3; i++) reset_cycle("rst");
    reset = 1'b0;
    cyc(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, "rst_first");

    // Round-robin over all four cores.
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, "rr0");
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, "rr1");
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, "rr2");
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, "rr3");
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, "rr4");

    // Burst limit: 8 restarts, one core 2 grant, then restarts resume.
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, "burst");
    cyc(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, "burst_hold");
    cyc(4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, "burst_resume");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, "idle0");

    // Stall mid-burst: burst count and rr pointer (3) must survive; hold persists through stall.
    for (int i = 0; i < 7; i++) cyc(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, "pre_stall");
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, "stall");
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, "stall_release");
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, "stall_hold");
    cyc(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000, "hold_after_stall");
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, "restart_again");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, "idle1");

    // Starvation boundary: core 3 at wait 15 loses to round-robin pick of core 0.
    for (int j = 0; j < 15; j++) begin
      cyc((j >= 10) ? 4'b1001 : 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, "starve_pre_a");
    end
    cyc(4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, "starve_edge");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, "idle2");

    // Starvation override: core 3 at wait 16 beats round-robin pick of core 1.
    for (int j = 0; j < 16; j++) begin
      cyc((j >= 10) ? 4'b1010 : 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, "starve_pre_b");
    end
    cyc(4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, "starve_override");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, "idle3");

`ifdef L2_SCHED_PERF_EN
    check("perf_restart", perf_r, 32'd19);
    check("perf_core", perf_c, 32'd9);
    check("perf_starve", perf_s, 32'd1);
`else
    check("perf_restart", perf_r, 32'd0);
    check("perf_core", perf_c, 32'd0);
    check("perf_starve", perf_s, 32'd0);
`endif

    // Reset while hold is set: hold and burst count must both clear.
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, "mid_burst");
    reset_cycle("mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, "post_rst_burst");
    cyc(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, "post_rst_hold");
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, "idle4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
